seg7_scan_display: RTL and testbench

//  Drives an 8-digit multiplexed 7-segment display from the 32-bit LedData word that the

---
 rtl/seg7_scan_display.sv | 106 ++++++++++
 tb/tb_seg7_scan_display.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Multiplexed 8-digit hex display driver. It scans one digit per CLK_DIV clocks and
// latches the input word only at frame wraps, so a single frame never mixes two values.
module seg7_scan_display #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        freeze,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic        tick;
    logic [4:0]  bit_base;
    logic [31:0] upper;
    logic [3:0]  nib;
    logic        blank;

    assign tick     = (div_cnt_q == DIV_LAST);
    assign bit_base = {idx_q, 2'b00};
    assign upper    = shadow_q >> bit_base;
    assign nib      = shadow_q[bit_base +: 4];
    assign blank    = blank_lz && (idx_q != 3'd0) && (upper == 32'h0);

    always_comb begin
        div_cnt_d = div_cnt_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        if (tick) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 3'd1;
            // freeze takes priority over the frame wrap
            if (idx_q == 3'd7 && !freeze) begin
                shadow_d = data_in;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_comb begin
        an_d  = ~(8'd1 << idx_q);
        seg_d = blank ? 7'h7F : hex7(nib);
        dp_d  = ~dp_mask[idx_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            idx_q     <= 3'd0;
            shadow_q  <= 32'h0;
            an_q      <= 8'hFF;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with CLK_DIV=4; outputs are sampled on the falling edge.
module tb_seg7_scan_display;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic        freeze;
    logic        blank_lz;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan_display #(.CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .freeze   (freeze),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] an_e,
                             input logic [6:0] seg_e, input logic dp_e);
        chk({tag, ".an"}, an, an_e);
        chk({tag, ".seg"}, {1'b0, seg}, {1'b0, seg_e});
        chk({tag, ".dp"}, {7'b0, dp}, {7'b0, dp_e});
    endtask

    // One digit slot: DIV clocks, all showing the same digit.
    task automatic slot(input string tag, input logic [7:0] an_e,
                        input logic [6:0] seg_e, input logic dp_e);
        for (int c = 0; c < DIV; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_out(tag, an_e, seg_e, dp_e);
        end
    endtask

    // segs packs digit i's expected pattern at segs[7*i +: 7].
    task automatic frame(input string tag, input logic [55:0] segs,
                         input logic [7:0] dpm, input int lo, input int hi);
        logic [7:0] a;
        for (int i = lo; i <= hi; i++) begin
            a = ~(8'd1 << i);
            slot($sformatf("%s.d%0d", tag, i), a, segs[7*i +: 7], ~dpm[i]);
        end
    endtask

    localparam logic [55:0] ALL0   = {8{7'h40}};
    localparam logic [55:0] F_89AB = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [55:0] F_1234 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
    localparam logic [55:0] F_20BL = {{6{7'h7F}}, 7'h24, 7'h40};
    localparam logic [55:0] F_0BL  = {{7{7'h7F}}, 7'h40};
    localparam logic [55:0] ALL_F  = {8{7'h0E}};

    initial begin
        rst      = 1'b1;
        data_in  = 32'h0;
        freeze   = 1'b0;
        blank_lz = 1'b0;
        dp_mask  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_out("reset", 8'hFF, 7'h7F, 1'b1);
        rst     = 1'b0;
        data_in = 32'h89ABCDEF;

        // First frame after reset shows the cleared shadow.
        frame("f1", ALL0, 8'h00, 0, 7);
        frame("f2", F_89AB, 8'h00, 0, 2);
        data_in = 32'h12345678;
        frame("f2", F_89AB, 8'h00, 3, 7);
        frame("f3", F_1234, 8'h00, 0, 3);
        data_in = 32'h00000020;
        frame("f3", F_1234, 8'h00, 4, 7);

        blank_lz = 1'b1;
        frame("f4", F_20BL, 8'h00, 0, 3);
        data_in = 32'h0;
        frame("f4", F_20BL, 8'h00, 4, 7);
        frame("f5", F_0BL, 8'h00, 0, 3);
        freeze  = 1'b1;
        data_in = 32'hFFFFFFFF;
        frame("f5", F_0BL, 8'h00, 4, 7);
        frame("f6frz", F_0BL, 8'h00, 0, 3);
        freeze = 1'b0;
        frame("f6frz", F_0BL, 8'h00, 4, 7);

        blank_lz = 1'b0;
        frame("f7", ALL_F, 8'h00, 0, 7);
        dp_mask = 8'h10;
        frame("f8", ALL_F, 8'h10, 0, 4);

        // Two clocks into digit 5, then reset.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_out("f8.d5", 8'hDF, 7'h0E, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_out("midrst", 8'hFF, 7'h7F, 1'b1);
        rst = 1'b0;
        frame("rs", ALL0, 8'h10, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
